// File: rtl/prt_dprx_lnk_sym_dec.sv
// DisplayPort RX link symbol decoder for one lane. It classifies 8b/10b-decoded symbols,
// folds the enhanced-framing BS/BE/SR sequences into single events and tracks framing lock.
`timescale 1ns/1ps
module prt_dprx_lnk_sym_dec #(
   parameter int P_LOCK_CNT   = 4,
   parameter int P_UNLOCK_CNT = 3
) (
   input  logic       CLK_IN,
   input  logic       RST_IN,
   input  logic       EN_IN,
   input  logic       EFM_IN,
   input  logic       SYM_VLD_IN,
   input  logic [8:0] SYM_IN,
   output logic       VLD_OUT,
   output logic [5:0] SYM_OUT,
   output logic [7:0] DAT_OUT,
   output logic       ERR_OUT,
   output logic       LOCK_OUT
);
   localparam logic [5:0] C_BS  = 6'd0;
   localparam logic [5:0] C_BE  = 6'd1;
   localparam logic [5:0] C_SS  = 6'd3;
   localparam logic [5:0] C_SE  = 6'd6;
   localparam logic [5:0] C_FS  = 6'd12;
   localparam logic [5:0] C_FE  = 6'd13;
   localparam logic [5:0] C_SR  = 6'd16;
   localparam logic [5:0] C_DAT = 6'd19;
   localparam logic [5:0] C_NOP = 6'd20;

   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] K27_7 = 8'hFB;
   localparam logic [7:0] K28_2 = 8'h5C;
   localparam logic [7:0] K29_7 = 8'hFD;
   localparam logic [7:0] K30_7 = 8'hFE;
   localparam logic [7:0] K23_7 = 8'hF7;
   localparam logic [7:0] K28_0 = 8'h1C;
   localparam logic [8:0] SYM_BF = 9'h17C;

   localparam int GW = $clog2(P_LOCK_CNT + 1);
   localparam int EW = $clog2(P_UNLOCK_CNT + 1);
   localparam logic [GW-1:0] GOOD_MAX = GW'(P_LOCK_CNT);
   localparam logic [EW-1:0] ERR_MAX  = EW'(P_UNLOCK_CNT);

   logic [8:0]    win_q [4];
   logic [8:0]    win_nxt [4];
   logic [2:0]    fill_q;
   logic [1:0]    sup_q, sup_d;
   logic [GW-1:0] good_q, good_d;
   logic [EW-1:0] errc_q, errc_d;
   logic          lock_q, lock_d;
   logic          vld_q, err_q;
   logic [5:0]    sym_q;
   logic [7:0]    dat_q;

   logic          accept, ev_en;
   logic [5:0]    h_code, o_code;
   logic          h_err, o_err;
   logic          head_frm, seq_match, good_ev;

   assign accept = SYM_VLD_IN & EN_IN;
   assign ev_en  = accept && (fill_q == 3'd4);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_win
         if (gi == 3) begin : g_tail
            assign win_nxt[gi] = SYM_IN;
         end else begin : g_body
            assign win_nxt[gi] = win_q[gi+1];
         end
      end
   endgenerate

   always_comb begin
      h_code = C_NOP;
      h_err  = 1'b1;
      if (!win_q[0][8]) begin
         h_code = C_DAT;
         h_err  = 1'b0;
      end else begin
         case (win_q[0][7:0])
            K28_5:   begin h_code = C_BS; h_err = 1'b0; end
            K27_7:   begin h_code = C_BE; h_err = 1'b0; end
            K28_2:   begin h_code = C_SS; h_err = 1'b0; end
            K29_7:   begin h_code = C_SE; h_err = 1'b0; end
            K30_7:   begin h_code = C_FS; h_err = 1'b0; end
            K23_7:   begin h_code = C_FE; h_err = 1'b0; end
            K28_0:   begin h_code = C_SR; h_err = 1'b0; end
            default: begin h_code = C_NOP; h_err = 1'b1; end
         endcase
      end
   end

   assign head_frm  = (h_code == C_BS) || (h_code == C_BE) || (h_code == C_SR);
   assign seq_match = (win_q[1] == SYM_BF) && (win_q[2] == SYM_BF) && (win_q[3] == win_q[0]);

   // A pending suppress count always wins, even if EFM_IN has since dropped.
   always_comb begin
      o_code = h_code;
      o_err  = h_err;
      sup_d  = sup_q;
      if (sup_q != 2'd0) begin
         o_code = C_NOP;
         o_err  = 1'b0;
         sup_d  = sup_q - 2'd1;
      end else if (EFM_IN && head_frm) begin
         if (seq_match) sup_d = 2'd3;
         else           o_err = 1'b1;
      end
   end

   assign good_ev = !o_err && ((o_code == C_BS) || (o_code == C_SR));

   always_comb begin
      good_d = good_q;
      errc_d = errc_q;
      lock_d = lock_q;
      if (ev_en) begin
         if (o_err) begin
            good_d = '0;
            if (errc_q != ERR_MAX) errc_d = errc_q + 1'b1;
         end else if (good_ev) begin
            errc_d = '0;
            if (good_q != GOOD_MAX) good_d = good_q + 1'b1;
         end
      end
      if (errc_d == ERR_MAX)       lock_d = 1'b0;
      else if (good_d == GOOD_MAX) lock_d = 1'b1;
   end

   always_ff @(posedge CLK_IN or negedge RST_IN) begin
      if (!RST_IN) begin
         win_q  <= '{default: '0};
         fill_q <= '0;
         sup_q  <= '0;
         good_q <= '0;
         errc_q <= '0;
         lock_q <= 1'b0;
         vld_q  <= 1'b0;
         sym_q  <= C_NOP;
         dat_q  <= '0;
         err_q  <= 1'b0;
      end else if (!EN_IN) begin
         fill_q <= '0;
         sup_q  <= '0;
         good_q <= '0;
         errc_q <= '0;
         lock_q <= 1'b0;
         vld_q  <= 1'b0;
      end else begin
         vld_q  <= ev_en;
         lock_q <= lock_d;
         if (accept) begin
            win_q <= win_nxt;
            if (fill_q != 3'd4) fill_q <= fill_q + 3'd1;
         end
         if (ev_en) begin
            sym_q  <= o_code;
            dat_q  <= win_q[0][7:0];
            err_q  <= o_err;
            sup_q  <= sup_d;
            good_q <= good_d;
            errc_q <= errc_d;
         end
      end
   end

   assign VLD_OUT  = vld_q;
   assign SYM_OUT  = sym_q;
   assign DAT_OUT  = dat_q;
   assign ERR_OUT  = err_q;
   assign LOCK_OUT = lock_q;
endmodule

// File: doc/prt_dprx_lnk_sym_dec.md
# prt_dprx_lnk_sym_dec

Receive-side link symbol decoder for one DisplayPort main-link lane.
- **Input:** one 8b/10b-decoded symbol per accepted cycle, as a K flag plus a byte.
- **Output:** one classified link symbol per accepted cycle, coded in `prt_dp_tx_lnk_sym` numbering so TX and RX share one symbol vocabulary.
- **Enhanced framing:** the four-symbol BS/BE/SR sequences collapse into single events.
- **Lock status:** framing lock is reported to the lane aligner and the main-stream depacketizer downstream.

## Interface
Parameters:
- P_LOCK_CNT, default 4: consecutive good BS/SR events required to assert lock.
- P_UNLOCK_CNT, default 3: errors without an intervening good BS/SR that drop lock.

Ports:
- CLK_IN  in  1  link symbol clock.
- RST_IN  in  1  reset; asynchronous, active-low.
- EN_IN  in  1  decoder enable; low synchronously flushes the window, counters and lock.
- EFM_IN  in  1  enhanced framing mode.
- SYM_VLD_IN  in  1  symbol accept strobe.
- SYM_IN  in  9  [8] = K flag, [7:0] = byte.
- VLD_OUT  out  1  output strobe.
- SYM_OUT  out  6  symbol code, `prt_dp_tx_lnk_sym` values.
- DAT_OUT  out  8  byte of the decoded head symbol.
- ERR_OUT  out  1  framing or code error on this output symbol.
- LOCK_OUT  out  1  framing lock.

## Operation
**Window**
- Four-entry shift window S0 (oldest) to S3 (newest).
- A fill counter runs 0..4.
- Each accept (SYM_VLD_IN=1 and EN_IN=1) evaluates S0 against S1..S3, then shifts SYM_IN into S3.
- Evaluation only produces output when fill=4.

**Per-symbol classification of S0**
- K=0: DAT (19), DAT_OUT = byte.
- K28.5: BS (0).
- K27.7: BE (1).
- K28.2: SS (3).
- K29.7: SE (6).
- K30.7: FS (12).
- K23.7: FE (13).
- K28.0: SR (16).
- Stray K28.3 (BF), K28.6, or any other K code: NOP (20) with ERR_OUT=1.

**Enhanced framing (EFM_IN=1) and head S0 ∈ {BS, BE, SR}**
- Match when S1=BF, S2=BF and S3=S0. Action:
  - emit the head code;
  - load the suppress counter with 3;
  - the next three accepts emit NOP with ERR_OUT=0.
- Mismatch: emit the head code with ERR_OUT=1. The suppress counter is not loaded, so the following symbols are decoded individually.
- While the suppress counter is nonzero, classification is skipped and NOP is emitted.

**Normal framing (EFM_IN=0)**
- BS, BE and SR decode singly.
- BF is an error.

**Lock**
- Good event: a BS/SR emitted with ERR_OUT=0.
  - Increments the good counter, saturating at P_LOCK_CNT.
  - Clears the error counter.
- Any output with ERR_OUT=1:
  - clears the good counter;
  - increments the error counter, saturating at P_UNLOCK_CNT.
- LOCK_OUT sets when the good counter reaches P_LOCK_CNT.
- LOCK_OUT clears when the error counter reaches P_UNLOCK_CNT.
- If both happen on the same edge, clear wins.

**EN_IN low**
- On the next edge:
  - fill, suppress, good and error counters go to 0;
  - LOCK_OUT=0, VLD_OUT=0;
  - window contents become don't-care.

**EFM_IN**
- EFM_IN is sampled at evaluation time.
- Changing EFM_IN while a suppress count is pending does not cancel the suppression.

## Timing
**Reset values**
- VLD_OUT=0, SYM_OUT=20 (NOP), DAT_OUT=0, ERR_OUT=0, LOCK_OUT=0.
- All counters are 0.

**Outputs**
- All outputs are registered.
- VLD_OUT pulses for one cycle per accept once fill=4.
- With SYM_VLD_IN low, VLD_OUT=0 and the other outputs hold their values.

**Latency and flow**
- Continuous accepts: a symbol accepted at edge t appears at the output at edge t+4.
- The first VLD_OUT occurs on the 5th accept after enable or reset.
- Gaps in SYM_VLD_IN stall the window; no symbol is dropped or duplicated.

**Lock timing**
- LOCK_OUT updates on the same edge as the VLD_OUT that carries the triggering event.

**Reset mid-operation**
- Asynchronous reset forces the reset values immediately.
- Lock is reacquired from zero.

## Test plan
- **EFM_IN=1, stream "BS BF BF BS, D00..D03" repeated 5×:**
  - each sequence emits BS, ERR=0, followed by three NOPs;
  - data emits DAT 00..03;
  - LOCK_OUT rises on the output of the 4th BS;
  - first VLD_OUT occurs on the 5th accept.
- **EFM_IN=1, "BS BF D55 BS":**
  - BS is emitted with ERR_OUT=1;
  - then NOP+ERR for the stray BF, DAT 55, and BS decoded with its own lookahead;
  - after 3 errors, LOCK_OUT falls.
- **EFM_IN=0, each K code in turn:**
  - SYM_OUT = 0/1/3/6/12/13/16 for the valid codes;
  - K28.3 and K28.6 give 20 with ERR_OUT=1.
- **Locked, continuous stream with SYM_VLD_IN deasserted for 7 random single cycles:**
  - the output sequence is identical to the gap-free run;
  - VLD_OUT count equals the accept count minus 4.
- **Suppress count pending, EN_IN pulsed low for 1 cycle:**
  - LOCK_OUT=0 and VLD_OUT=0 on the next edge;
  - the next VLD_OUT comes only after 4 fresh accepts plus one.
- **RST_IN asserted asynchronously mid-sequence (between edges):**
  - outputs go to reset values without waiting for a clock edge;
  - after release, lock is reacquired after P_LOCK_CNT good BS events.
